// File: rtl/gcd_job_sequencer.sv
// Job front-end for the subtractive GCD engine: queues operand pairs, issues A then B, returns the result.
// Optional GCD_SEQ_ZERO_BYPASS_EN answers zero-operand jobs locally instead of sending them to the engine.
module gcd_job_sequencer #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [2:0]       state;
    logic [WIDTH-1:0] job_b;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             push;
    logic             pop;

    // Full blocks the producer even if the head leaves this cycle: no pass-through.
    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (count != '0);
    assign busy     = (state != S_IDLE) || (count != '0);
    assign head_a   = mem_a[rd_ptr];
    assign head_b   = mem_b[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            job_b     <= '0;
            gcd_start <= 1'b0;
            gcd_data  <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        job_b <= head_b;
`ifdef GCD_SEQ_ZERO_BYPASS_EN
                        // A zero operand would stall the subtractive engine forever.
                        if ((head_a == '0) || (head_b == '0)) begin
                            out_gcd   <= (head_a == '0) ? head_b : head_a;
                            out_valid <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            gcd_start <= 1'b1;
                            gcd_data  <= head_a;
                            state     <= S_START;
                        end
`else
                        gcd_start <= 1'b1;
                        gcd_data  <= head_a;
                        state     <= S_START;
`endif
                    end
                end
                S_START: begin
                    gcd_start <= 1'b0;
                    gcd_data  <= job_b;
                    state     <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (gcd_done) begin
                        out_gcd   <= gcd_result;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    gcd_start <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Front-end stage placed directly upstream of the GCD engine (datapath plus controller).
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives the engine's start strobe and its serial operand bus: A, then B on consecutive cycles.
- Waits for the engine's done, captures the result and presents it on a valid/ready output.

Parameters:
- WIDTH, 16, operand/result width; must match the engine's data_in width.
- FIFO_DEPTH, 2, input job FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  FIFO can accept; equals !full
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- gcd_start  output  1  start strobe to engine controller
- gcd_data  output  WIDTH  operand bus to engine data_in
- gcd_done  input  1  engine done, level
- gcd_result  input  WIDTH  engine result register (aout)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_gcd  output  WIDTH  captured GCD
- busy  output  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied, pointers and count = 0, state = IDLE.
  - gcd_start=0, gcd_data=0, out_valid=0, out_gcd=0, busy=0, in_ready=1.
- FIFO:
  - Push when in_valid & in_ready; pop only in IDLE when non-empty.
  - When full, in_ready=0 even if a pop happens the same cycle (no pass-through).
  - Pointers wrap modulo FIFO_DEPTH; count is (log2(FIFO_DEPTH)+1) bits.
- All outputs are registered. State machine:
  - IDLE: if FIFO non-empty, pop head into job regs A/B and go to START.
  - START (1 cycle): gcd_start=1, gcd_data=A. Next state LOAD_B.
  - LOAD_B (1 cycle): gcd_start=0, gcd_data=B. Next state WAIT.
  - WAIT: gcd_data holds B. On gcd_done=1, capture out_gcd <= gcd_result, set out_valid=1, go to OUT. gcd_done is ignored in START and LOAD_B.
  - OUT: out_valid=1, out_gcd stable. On out_ready=1, clear out_valid and go to IDLE.
- A new job starts no earlier than the cycle after the result handshake; at most one job is in the engine at a time.
- Latency, measured from the cycle a job is at the FIFO head in IDLE:
  - gcd_start high at +1.
  - B on gcd_data at +2.
  - out_valid high 1 cycle after gcd_done is first sampled high in WAIT.
- Capacity: FIFO_DEPTH jobs queued plus one in flight.
- Width: no arithmetic in this block; operands and result are passed through unmodified at WIDTH bits.
- Reset mid-operation: the job is discarded silently with no output. The engine has no reset and must be returned to its idle state by bench or system reset sequencing; gcd_start stays 0 while rst_n=0.
- in_valid while in_ready=0: ignored, nothing stored. The producer must hold the data until accepted.

Optional Feature:
- Macro: GCD_SEQ_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a popped job with A==0 or B==0 skips START/LOAD_B/WAIT and goes directly to OUT the next cycle.
  - out_gcd = (A==0) ? B : A, so (0,0) gives 0.
  - gcd_start is not asserted for such jobs. This prevents the subtractive engine from hanging on a zero operand.
- Undefined: zero operands go to the engine like any other job; behaviour is the engine's, possibly never done.

Test Plan:
- Bench engine model: behavioural, drives gcd_done after 6 cycles with the correct GCD on gcd_result.
- Push (12,24), out_ready=1 -> gcd_start 1 cycle after pop with gcd_data=12, gcd_data=24 next cycle, then out_valid=1 with out_gcd=12 for one handshake.
- Push (17,5), then (48,18) back-to-back -> outputs 1 then 6 in order; gcd_start pulses exactly twice, each 1 cycle wide.
- out_ready=0, push 4 jobs continuously -> 3 accepted (2 queued + 1 in flight), in_ready=0 from then on. Release out_ready -> results drain in order and in_ready returns to 1.
- Assert rst_n=0 during WAIT of job (100,75) -> out_valid=0, busy=0, in_ready=1 immediately (async). After release, job (9,6) -> 3.
- With GCD_SEQ_ZERO_BYPASS_EN: push (0,35) -> out_gcd=35 two cycles after push, gcd_start never asserted. Without the macro: gcd_start asserts for the same job.
